imm_split_seq: RTL and testbench

//  Inverse of the immediate extender: takes a 32-bit constant and emits the

---
 rtl/imm_split_seq.sv | 145 ++++++++++++++
 tb/tb_imm_split_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_split_seq.sv
// rtl/imm_split_seq.sv - splits a 32-bit constant into the shortest (imm16, EXTOp) micro-op sequence
module imm_split_seq #(
    parameter int EN_HIGHPOS = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [15:0]      op_imm16,
    output logic [1:0]       op_ext,
    output logic             op_last,
    output logic [CNT_W-1:0] n_single,
    output logic [CNT_W-1:0] n_pair
);

    // EXTOp codes understood by the immediate extender
    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      imm_q, imm_d;
    logic [1:0]       ext_q, ext_d;
    logic             last_q, last_d;
    logic [15:0]      lo_q, lo_d;
    logic [CNT_W-1:0] n_single_q, n_single_d;
    logic [CNT_W-1:0] n_pair_q, n_pair_d;

    logic             hi_is_sign;
    logic             hi_is_zero;
    logic             lo_is_zero;

    // Classification terms for the constant presented at the input
    always_comb begin
        hi_is_sign = (in_data[31:16] == {16{in_data[15]}});
        hi_is_zero = (in_data[31:16] == 16'h0000);
        lo_is_zero = (in_data[15:0] == 16'h0000);
    end

    // Next-state and op-register load logic; op fields only change on a handshake
    always_comb begin
        state_d    = state_q;
        imm_d      = imm_q;
        ext_d      = ext_q;
        last_d     = last_q;
        lo_d       = lo_q;
        n_single_d = n_single_q;
        n_pair_d   = n_pair_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT1;
                    lo_d    = in_data[15:0];
                    if (hi_is_sign) begin
                        imm_d  = in_data[15:0];
                        ext_d  = EXT_SIGNED;
                        last_d = 1'b1;
                    end else if (hi_is_zero) begin
                        imm_d  = in_data[15:0];
                        ext_d  = EXT_ZERO;
                        last_d = 1'b1;
                    end else if ((EN_HIGHPOS != 0) && lo_is_zero) begin
                        imm_d  = in_data[31:16];
                        ext_d  = EXT_HIGHPOS;
                        last_d = 1'b1;
                    end else begin
                        // LUI-style upper half first, ORI-style lower half follows
                        imm_d  = in_data[31:16];
                        ext_d  = EXT_HIGHPOS;
                        last_d = 1'b0;
                    end
                end
            end
            EMIT1: begin
                if (op_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        if (n_single_q != {CNT_W{1'b1}}) begin
                            n_single_d = n_single_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = EMIT2;
                        imm_d   = lo_q;
                        ext_d   = EXT_ZERO;
                        last_d  = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (op_ready) begin
                    state_d = IDLE;
                    if (n_pair_q != {CNT_W{1'b1}}) begin
                        n_pair_d = n_pair_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, op and counter registers; reset drops any pending constant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            imm_q      <= 16'h0000;
            ext_q      <= EXT_ZERO;
            last_q     <= 1'b0;
            lo_q       <= 16'h0000;
            n_single_q <= '0;
            n_pair_q   <= '0;
        end else begin
            state_q    <= state_d;
            imm_q      <= imm_d;
            ext_q      <= ext_d;
            last_q     <= last_d;
            lo_q       <= lo_d;
            n_single_q <= n_single_d;
            n_pair_q   <= n_pair_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        in_ready = (state_q == IDLE);
        op_valid = (state_q != IDLE);
        op_imm16 = imm_q;
        op_ext   = ext_q;
        op_last  = last_q;
        n_single = n_single_q;
        n_pair   = n_pair_q;
    end

endmodule

// File: tb/tb_imm_split_seq.sv
// tb/tb_imm_split_seq.sv - self-checking bench for imm_split_seq
module tb_imm_split_seq;

    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  ext;
        logic        last;
    } op_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, op_valid, op_ready, op_last;
    logic [31:0] in_data;
    logic [15:0] op_imm16;
    logic [1:0]  op_ext;
    logic [15:0] n_single, n_pair;

    logic        in_valid_b, in_ready_b, op_valid_b, op_ready_b, op_last_b;
    logic [31:0] in_data_b;
    logic [15:0] op_imm16_b;
    logic [1:0]  op_ext_b;
    logic [1:0]  n_single_b, n_pair_b;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 0;
    int          rdy_mode = 0;
    op_t         exp_q[$];
    logic [31:0] v_q[$];
    logic [31:0] acc = 0;
    int          nops = 0;
    int          m_single = 0;
    int          m_pair = 0;

    imm_split_seq #(.EN_HIGHPOS(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .op_valid(op_valid), .op_ready(op_ready),
        .op_imm16(op_imm16), .op_ext(op_ext), .op_last(op_last),
        .n_single(n_single), .n_pair(n_pair)
    );

    imm_split_seq #(.EN_HIGHPOS(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .op_valid(op_valid_b), .op_ready(op_ready_b),
        .op_imm16(op_imm16_b), .op_ext(op_ext_b), .op_last(op_last_b),
        .n_single(n_single_b), .n_pair(n_pair_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: what the extender produces for one op
    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] ext);
        case (ext)
            EXT_ZERO:    return {16'h0000, imm};
            EXT_SIGNED:  return {{16{imm[15]}}, imm};
            EXT_HIGHPOS: return {imm, 16'h0000};
            default:     return 32'h0;
        endcase
    endfunction

    // Reference: shortest op sequence for a constant, by priority of extension modes
    function automatic int split(input logic [31:0] v, input bit hp, output op_t a, output op_t b);
        b = '0;
        if ($signed(v) >= -32768 && $signed(v) <= 32767) begin
            a = '{v[15:0], EXT_SIGNED, 1'b1};
            return 1;
        end
        if (v < 32'h0001_0000) begin
            a = '{v[15:0], EXT_ZERO, 1'b1};
            return 1;
        end
        if (hp && (v % 32'h0001_0000) == 0) begin
            a = '{v[31:16], EXT_HIGHPOS, 1'b1};
            return 1;
        end
        a = '{v[31:16], EXT_HIGHPOS, 1'b0};
        b = '{v[15:0], EXT_ZERO, 1'b1};
        return 2;
    endfunction

    // op_ready driver for the main instance
    initial begin
        op_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       op_ready = 1'b1;
                1:       op_ready = 1'($urandom_range(0, 1));
                default: op_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle scoreboard for the main instance
    always @(negedge clk) begin
        op_t         h, a, b;
        logic [31:0] v;
        int          n;
        if (chk_en && rst_n) begin
            chk("ready_while_busy", {31'b0, in_ready && op_valid}, 32'h0);
            chk("n_single", {16'h0, n_single}, m_single);
            chk("n_pair", {16'h0, n_pair}, m_pair);
            if (op_valid) begin
                if (exp_q.size() == 0) begin
                    chk("op_unexpected", 32'h1, 32'h0);
                end else begin
                    h = exp_q[0];
                    chk("op_imm16", {16'h0, op_imm16}, {16'h0, h.imm});
                    chk("op_ext", {30'h0, op_ext}, {30'h0, h.ext});
                    chk("op_last", {31'h0, op_last}, {31'h0, h.last});
                    if (op_ready) begin
                        h = exp_q.pop_front();
                        acc = acc | extend(op_imm16, op_ext);
                        nops++;
                        if (op_last) begin
                            v = (v_q.size() != 0) ? v_q.pop_front() : 32'hx;
                            chk("rebuild", acc, v);
                            if (nops == 1) m_single = (m_single < 65535) ? m_single + 1 : m_single;
                            else           m_pair   = (m_pair   < 65535) ? m_pair + 1   : m_pair;
                            acc  = 0;
                            nops = 0;
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                n = split(in_data, 1'b1, a, b);
                exp_q.push_back(a);
                if (n == 2) exp_q.push_back(b);
                v_q.push_back(in_data);
            end
        end
    end

    // Presents one constant to the main instance; call at posedge+1
    task automatic send_a(input logic [31:0] v);
        int t;
        in_valid = 1;
        in_data  = v;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 32'h1, 32'h0);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    // Waits until every expected op has been consumed
    task automatic drain_a();
        int t;
        t = 0;
        @(negedge clk);
        #1;
        while ((exp_q.size() != 0 || op_valid) && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", {31'h0, (exp_q.size() != 0 || op_valid)}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        op_t         a, b;
        int          n;
        logic [31:0] v;
        logic [15:0] r;

        rst_n = 0;
        in_valid = 0;  in_data = 0;
        in_valid_b = 0; in_data_b = 0; op_ready_b = 1;

        // Model pinned against hand-computed splits
        n = split(32'h0000_0000, 1'b1, a, b);
        chk("model_zero_n", n, 1);
        chk("model_zero_op", {13'h0, a}, {13'h0, 16'h0000, EXT_SIGNED, 1'b1});
        n = split(32'hFFFF_8000, 1'b1, a, b);
        chk("model_neg_op", {13'h0, a}, {13'h0, 16'h8000, EXT_SIGNED, 1'b1});
        n = split(32'h0000_FFFF, 1'b1, a, b);
        chk("model_zext_op", {13'h0, a}, {13'h0, 16'hFFFF, EXT_ZERO, 1'b1});
        n = split(32'h1234_0000, 1'b1, a, b);
        chk("model_hi_op", {13'h0, a}, {13'h0, 16'h1234, EXT_HIGHPOS, 1'b1});
        n = split(32'h1234_0000, 1'b0, a, b);
        chk("model_hi_nohp_n", n, 2);
        chk("model_hi_nohp_lo", {13'h0, b}, {13'h0, 16'h0000, EXT_ZERO, 1'b1});
        n = split(32'h1234_5678, 1'b1, a, b);
        chk("model_pair_hi", {13'h0, a}, {13'h0, 16'h1234, EXT_HIGHPOS, 1'b0});
        chk("model_pair_lo", {13'h0, b}, {13'h0, 16'h5678, EXT_ZERO, 1'b1});

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_op_imm16", {16'h0, op_imm16}, 32'h0);
        chk("rst_op_ext", {30'h0, op_ext}, {30'h0, EXT_ZERO});
        chk("rst_op_last", {31'h0, op_last}, 32'h0);
        chk("rst_n_single", {16'h0, n_single}, 32'h0);
        chk("rst_n_pair", {16'h0, n_pair}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk_en = 1;
        @(posedge clk);
        #1;

        // Instance without single-HIGHPOS and 2-bit counters
        in_valid_b = 1;
        in_data_b  = 32'h1234_0000;
        @(posedge clk);
        #1;
        in_valid_b = 0;
        @(negedge clk);
        chk("b_op1_valid", {31'h0, op_valid_b}, 32'h1);
        chk("b_op1", {13'h0, op_imm16_b, op_ext_b, op_last_b}, {13'h0, 16'h1234, EXT_HIGHPOS, 1'b0});
        @(negedge clk);
        chk("b_op2", {13'h0, op_imm16_b, op_ext_b, op_last_b}, {13'h0, 16'h0000, EXT_ZERO, 1'b1});
        @(negedge clk);
        chk("b_idle_valid", {31'h0, op_valid_b}, 32'h0);
        chk("b_n_pair", {30'h0, n_pair_b}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid_b = 1;
            in_data_b  = 32'h0000_0005;
            @(posedge clk);
            #1;
            in_valid_b = 0;
            @(negedge clk);
            chk("b_single_op", {13'h0, op_imm16_b, op_ext_b, op_last_b}, {13'h0, 16'h0005, EXT_SIGNED, 1'b1});
        end
        @(posedge clk);
        @(negedge clk);
        chk("b_n_single_sat", {30'h0, n_single_b}, 32'h3);
        chk("b_n_pair_hold", {30'h0, n_pair_b}, 32'h1);
        @(posedge clk);
        #1;

        // Directed single-op constants
        rdy_mode = 0;
        send_a(32'h0000_0000);
        send_a(32'hFFFF_8000);
        send_a(32'h0000_FFFF);
        send_a(32'h1234_0000);
        drain_a();
        chk("dir_n_single", {16'h0, n_single}, 32'd4);
        chk("dir_n_pair", {16'h0, n_pair}, 32'd0);

        // Pair with consumer stalled three cycles
        rdy_mode = 2;
        send_a(32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, op_valid}, 32'h1);
            chk("hold_op", {13'h0, op_imm16, op_ext, op_last}, {13'h0, 16'h1234, EXT_HIGHPOS, 1'b0});
        end
        rdy_mode = 0;
        drain_a();
        chk("hold_n_pair", {16'h0, n_pair}, 32'd1);
        chk("hold_n_single", {16'h0, n_single}, 32'd4);

        // Random constants, back-to-back, random consumer
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = {{16{r[15]}}, r};
                2:       v = {16'h0000, r};
                default: v = {r, 16'h0000};
            endcase
            send_a(v);
        end
        rdy_mode = 0;
        drain_a();

        // Reset while the second op of a pair is pending
        rdy_mode = 2;
        send_a(32'hDEAD_BEEF);
        @(negedge clk);
        rdy_mode = 0;
        @(posedge clk);
        #3;
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("emit2_op", {13'h0, op_imm16, op_ext, op_last}, {13'h0, 16'hBEEF, EXT_ZERO, 1'b1});
        #2;
        chk_en = 0;
        rst_n = 0;
        #1;
        chk("midrst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("midrst_n_single", {16'h0, n_single}, 32'h0);
        chk("midrst_n_pair", {16'h0, n_pair}, 32'h0);
        chk("midrst_b_counters", {28'h0, n_single_b, n_pair_b}, 32'h0);
        exp_q.delete();
        v_q.delete();
        acc = 0;
        nops = 0;
        m_single = 0;
        m_pair = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("post_rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk_en = 1;
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_a(32'h8765_4321);
        send_a(32'h0000_7FFF);
        rdy_mode = 0;
        drain_a();
        chk("post_rst_n_single", {16'h0, n_single}, 32'd1);
        chk("post_rst_n_pair", {16'h0, n_pair}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
